hamming_scrub_ctrl: RTL and testbench



---
 rtl/hamming_scrub_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrub_ctrl.sv
// Hamming(7,4) RAM controller: host read/write port plus a background scrubber
// that walks every address and writes back any word with a non-zero syndrome.
module hamming_scrub_ctrl #(
   parameter int ADDR_W         = 4,
   parameter int SCRUB_INTERVAL = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [3:0]        host_wdata,
   output logic              host_ack,
   output logic [3:0]        host_rdata,
   output logic              host_corr,
   input  logic              scrub_en,
   input  logic              err_cnt_clr,
   output logic [7:0]        err_count,
   output logic [2:0]        last_syndrome,
   output logic              scrub_pass_done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [6:0]        mem_wdata,
   input  logic [6:0]        mem_rdata
);

   localparam int               CNT_W    = $clog2(SCRUB_INTERVAL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);

   typedef enum logic [2:0] {
      IDLE,
      H_WR,
      H_RD,
      H_DEC,
      S_RD,
      S_CHK,
      S_WB
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  iv_cnt;
   logic              iv_wrap;
   logic              scrub_pending;
   logic              take_scrub;
   logic [ADDR_W-1:0] scrub_ptr, scrub_ptr_d;

   logic [2:0]        dec_syn;
   logic [6:0]        dec_code;
   logic [3:0]        dec_data;

   logic              host_ack_d, host_corr_d, mem_re_d, mem_we_d, pass_done_d, busy_d;
   logic [3:0]        host_rdata_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [6:0]        mem_wdata_d;
   logic [2:0]        last_syn_d;
   logic [7:0]        err_count_d;
   logic              advance, err_inc;

   // Codeword layout {d3,d2,d1,p3,d0,p2,p1}, position i held in code[i-1].
   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
   endfunction

   always_comb begin
      dec_syn  = syndrome(mem_rdata);
      dec_code = mem_rdata;
      if (dec_syn != '0) dec_code = mem_rdata ^ (7'd1 << (dec_syn - 3'd1));
      dec_data = {dec_code[6], dec_code[5], dec_code[4], dec_code[2]};
   end

   assign iv_wrap = (iv_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      take_scrub = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_req) begin
               state_d = host_we ? H_WR : H_RD;
            end else if (scrub_pending && scrub_en) begin
               state_d    = S_RD;
               take_scrub = 1'b1;
            end
         end
         H_WR:    state_d = IDLE;
         H_RD:    state_d = H_DEC;
         H_DEC:   state_d = IDLE;
         S_RD:    state_d = S_CHK;
         S_CHK:   state_d = (dec_syn != '0) ? S_WB : IDLE;
         S_WB:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered: strobes for a state are loaded on the edge entering
   // it, decode results on the edge leaving H_DEC/S_CHK.
   always_comb begin
      host_ack_d   = 1'b0;
      host_rdata_d = '0;
      host_corr_d  = 1'b0;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      last_syn_d   = last_syndrome;
      err_count_d  = err_count;
      scrub_ptr_d  = scrub_ptr;
      pass_done_d  = 1'b0;
      advance      = 1'b0;
      err_inc      = 1'b0;
      busy_d       = (state_d != IDLE);

      case (state_d)
         H_WR: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = host_addr;
            mem_wdata_d = encode(host_wdata);
            host_ack_d  = 1'b1;
         end
         H_RD: begin
            mem_re_d   = 1'b1;
            mem_addr_d = host_addr;
         end
         S_RD: begin
            mem_re_d   = 1'b1;
            mem_addr_d = scrub_ptr;
         end
         S_WB: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = scrub_ptr;
            mem_wdata_d = dec_code;
         end
         default: ;
      endcase

      case (state_q)
         H_DEC: begin
            host_ack_d   = 1'b1;
            host_rdata_d = dec_data;
            host_corr_d  = (dec_syn != '0);
         end
         S_CHK:   advance = (dec_syn == '0);
         S_WB: begin
            advance = 1'b1;
            err_inc = 1'b1;
         end
         default: ;
      endcase

      if ((state_q == H_DEC || state_q == S_CHK) && dec_syn != '0) last_syn_d = dec_syn;

      if (advance) begin
         scrub_ptr_d = scrub_ptr + ADDR_W'(1);
         pass_done_d = (scrub_ptr == '1);
      end

      if (err_cnt_clr)                         err_count_d = '0;
      else if (err_inc && err_count != 8'hFF)  err_count_d = err_count + 8'd1;
   end

   // A wrap coinciding with the IDLE hand-off re-arms the flag rather than losing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iv_cnt        <= '0;
         scrub_pending <= 1'b0;
      end else begin
         iv_cnt <= iv_wrap ? '0 : iv_cnt + CNT_W'(1);
         if (iv_wrap && scrub_en) scrub_pending <= 1'b1;
         else if (take_scrub)     scrub_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_ack        <= 1'b0;
         host_rdata      <= '0;
         host_corr       <= 1'b0;
         err_count       <= '0;
         last_syndrome   <= '0;
         scrub_pass_done <= 1'b0;
         busy            <= 1'b0;
         mem_addr        <= '0;
         mem_re          <= 1'b0;
         mem_we          <= 1'b0;
         mem_wdata       <= '0;
         scrub_ptr       <= '0;
      end else begin
         host_ack        <= host_ack_d;
         host_rdata      <= host_rdata_d;
         host_corr       <= host_corr_d;
         err_count       <= err_count_d;
         last_syndrome   <= last_syn_d;
         scrub_pass_done <= pass_done_d;
         busy            <= busy_d;
         mem_addr        <= mem_addr_d;
         mem_re          <= mem_re_d;
         mem_we          <= mem_we_d;
         mem_wdata       <= mem_wdata_d;
         scrub_ptr       <= scrub_ptr_d;
      end
   end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Bench for hamming_scrub_ctrl: table of host transactions against a behavioural
// ECC RAM, plus directed scrub, arbitration, saturation and reset sequences.
module tb_hamming_scrub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       host_req, host_we;
   logic [3:0] host_addr, host_wdata;
   logic       host_ack, host_corr;
   logic [3:0] host_rdata;
   logic       scrub_en, err_cnt_clr;
   logic [7:0] err_count;
   logic [2:0] last_syndrome;
   logic       scrub_pass_done, busy;
   logic [3:0] mem_addr;
   logic       mem_re, mem_we;
   logic [6:0] mem_wdata;
   logic [6:0] mem_rdata = '0;

   logic [6:0] ram [16];
   logic       pre_clr, pre_we, inject;
   logic [3:0] pre_addr;
   logic [6:0] pre_data;

   int n_chk  = 0;
   int n_fail = 0;

   hamming_scrub_ctrl #(.ADDR_W(4), .SCRUB_INTERVAL(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .host_corr(host_corr),
      .scrub_en(scrub_en), .err_cnt_clr(err_cnt_clr), .err_count(err_count),
      .last_syndrome(last_syndrome), .scrub_pass_done(scrub_pass_done), .busy(busy),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM; inject flips code[0] on every read to force corrections.
   always @(posedge clk) begin
      if (pre_clr) begin
         for (int i = 0; i < 16; i++) ram[i] <= '0;
      end else if (pre_we) begin
         ram[pre_addr] <= pre_data;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      if (mem_re) mem_rdata <= ram[mem_addr] ^ {6'b0, inject};
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [3:0] wdata;
      logic [6:0] code;
      logic [3:0] rdata;
      logic       corr;
      logic [2:0] syn;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] a, input logic [6:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic clear_ram();
      pre_clr = 1'b1;
      tick();
      pre_clr = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ack"},   host_ack, 0);
      check({tag, "_rdata"}, host_rdata, 0);
      check({tag, "_corr"},  host_corr, 0);
      check({tag, "_errc"},  err_count, 0);
      check({tag, "_lsyn"},  last_syndrome, 0);
      check({tag, "_pass"},  scrub_pass_done, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_maddr"}, mem_addr, 0);
      check({tag, "_mre"},   mem_re, 0);
      check({tag, "_mwe"},   mem_we, 0);
      check({tag, "_mwd"},   mem_wdata, 0);
   endtask

   task automatic wait_we(input string tag, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         tick();
         if (mem_we) ok = 1'b1;
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: got no mem_we within 40 cycles, expected a writeback", tag);
      end
   endtask

   initial begin
      bit   ok, got, pass_seen;
      int   nwe, npass, since;
      logic [3:0] we_addr;
      logic [6:0] we_data;

      vecs[0] = '{1'b1, 4'd3,  4'b1010, 7'b1010010, 4'b0000, 1'b0, 3'd0};
      vecs[1] = '{1'b0, 4'd3,  4'b0000, 7'b1010010, 4'b1010, 1'b0, 3'd0};
      vecs[2] = '{1'b0, 4'd3,  4'b0000, 7'b1010110, 4'b1010, 1'b1, 3'd3};
      vecs[3] = '{1'b1, 4'd0,  4'b0000, 7'b0000000, 4'b0000, 1'b0, 3'd0};
      vecs[4] = '{1'b1, 4'd15, 4'b1111, 7'b1111111, 4'b0000, 1'b0, 3'd0};
      vecs[5] = '{1'b1, 4'd7,  4'b0110, 7'b0110011, 4'b0000, 1'b0, 3'd0};
      vecs[6] = '{1'b0, 4'd7,  4'b0000, 7'b0110010, 4'b0110, 1'b1, 3'd1};
      vecs[7] = '{1'b0, 4'd15, 4'b0000, 7'b1110111, 4'b1111, 1'b1, 3'd4};
      vecs[8] = '{1'b0, 4'd0,  4'b0000, 7'b0000000, 4'b0000, 1'b0, 3'd4};
      vecs[9] = '{1'b0, 4'd9,  4'b0000, 7'b0000011, 4'b0001, 1'b1, 3'd3};

      rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      scrub_en = 1'b0; err_cnt_clr = 1'b0; pre_clr = 1'b0; pre_we = 1'b0; inject = 1'b0;
      pre_addr = '0; pre_data = '0;
      tick(); tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      clear_ram();

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
            tick();
            check("wr_mem_we",    mem_we, 1);
            check("wr_mem_addr",  mem_addr, vecs[i].addr);
            check("wr_mem_wdata", mem_wdata, vecs[i].code);
            check("wr_ack",       host_ack, 1);
            host_req = 1'b0;
            tick();
            check("wr_ack_pulse", host_ack, 0);
            check("wr_we_pulse",  mem_we, 0);
         end else begin
            preload(vecs[i].addr, vecs[i].code);
            host_req = 1'b1; host_we = 1'b0; host_addr = vecs[i].addr;
            tick();
            check("rd_mem_re",   mem_re, 1);
            check("rd_mem_addr", mem_addr, vecs[i].addr);
            check("rd_ack_early", host_ack, 0);
            tick();
            check("rd_ack_early2", host_ack, 0);
            check("rd_no_we1", mem_we, 0);
            tick();
            check("rd_ack",   host_ack, 1);
            check("rd_rdata", host_rdata, vecs[i].rdata);
            check("rd_corr",  host_corr, vecs[i].corr);
            check("rd_lsyn",  last_syndrome, vecs[i].syn);
            check("rd_no_we2", mem_we, 0);
            host_req = 1'b0;
            tick();
         end
      end

      // Back-to-back reads: request held through the ack cycle with a new address.
      preload(4'd3, 7'b1010010);
      preload(4'd4, 7'b1111111);
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
      tick(); tick(); tick();
      check("b2b_ack1",   host_ack, 1);
      check("b2b_rdata1", host_rdata, 4'b1010);
      host_addr = 4'd4;
      tick();
      check("b2b_re2",   mem_re, 1);
      check("b2b_addr2", mem_addr, 4);
      tick(); tick();
      check("b2b_ack2",   host_ack, 1);
      check("b2b_rdata2", host_rdata, 4'b1111);
      host_req = 1'b0;
      tick();

      // Host keeps winning while a scrub request is pending; scrub follows the last ack.
      scrub_en = 1'b1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
      for (int k = 0; k < 8; k++) begin
         got = 1'b0;
         for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (host_ack) got = 1'b1;
         end
         if (!got) begin
            check("prio_ack_timeout", 0, 1);
            break;
         end
      end
      host_req = 1'b0;
      tick();
      check("prio_scrub_re",   mem_re, 1);
      check("prio_scrub_addr", mem_addr, 0);
      check("prio_busy",       busy, 1);
      tick();
      host_req = 1'b1; host_addr = 4'd3;
      tick();
      check("wait_idle_busy", busy, 0);
      check("wait_idle_re",   mem_re, 0);
      tick();
      check("wait_host_re",   mem_re, 1);
      check("wait_host_addr", mem_addr, 3);
      tick(); tick();
      check("wait_host_ack",  host_ack, 1);
      host_req = 1'b0;
      scrub_en = 1'b0;
      tick();

      // Full scrub pass with one corrupted word at address 5.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      clear_ram();
      preload(4'd5, 7'b0010010);
      scrub_en = 1'b1;
      nwe = 0; npass = 0; since = 0; pass_seen = 1'b0; we_addr = '0; we_data = '0;
      for (int c = 0; c < 600; c++) begin
         tick();
         if (mem_we) begin
            nwe++;
            we_addr = mem_addr;
            we_data = mem_wdata;
         end
         if (scrub_pass_done) begin
            npass++;
            pass_seen = 1'b1;
         end
         if (pass_seen) since++;
         if (since >= 6) break;
      end
      check("scrub_pass_pulses", npass, 1);
      check("scrub_wb_count",    nwe, 1);
      check("scrub_wb_addr",     we_addr, 5);
      check("scrub_wb_data",     we_data, 7'b1010010);
      check("scrub_err_count",   err_count, 1);
      check("scrub_last_syn",    last_syndrome, 7);
      check("scrub_ram5",        ram[5], 7'b1010010);
      scrub_en = 1'b0;

      // Saturation and clear priority, every read corrupted by the RAM model.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      clear_ram();
      inject = 1'b1;
      scrub_en = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 255 && ok; i++) wait_we("sat_fill", ok);
      tick(); tick();
      check("sat_at_255", err_count, 255);
      wait_we("sat_extra", ok);
      tick(); tick();
      check("sat_hold_255", err_count, 255);
      wait_we("clr_coinc1", ok);
      err_cnt_clr = 1'b1;
      tick();
      err_cnt_clr = 1'b0;
      check("clr_wins_255", err_count, 0);
      wait_we("inc_after_clr", ok);
      tick();
      check("inc_after_clr", err_count, 1);
      wait_we("clr_coinc2", ok);
      err_cnt_clr = 1'b1;
      tick();
      err_cnt_clr = 1'b0;
      check("clr_wins_1", err_count, 0);

      // Reset asserted in the middle of a writeback.
      wait_we("rst_wb", ok);
      check("rst_wb_we_before", mem_we, 1);
      #1 rst_n = 1'b0;
      #1;
      check_outputs_zero("rst_in_wb");
      #2;
      rst_n = 1'b1;
      inject = 1'b0;
      scrub_en = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
